down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Programmable down-counting timer: the decrementing counterpart to the free-running asynchronous-reset up counter.
- Loads a start value, counts down to zero on prescaled ticks, and flags terminal count.
- Supports one-shot and auto-reload (periodic) operation, with pause and resume.
- Used as a general delay/timeout/period generator next to the up counter in the same clock domain.

Parameters:
- WIDTH, 4, bit width of count, load_val and the reload register.
- PRESCALE, 1, clk cycles per count tick; legal range 1..256. PRESCALE=1 means a tick every clk.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- load  input  1  sync load strobe: reload_reg<=load_val, count<=load_val.
- load_val  input  WIDTH  value captured on load.
- start  input  1  start, resume or restart strobe.
- stop  input  1  pause strobe.
- auto_reload  input  1  1=periodic, 0=one-shot; sampled on every tick.
- count  output  WIDTH  current count value (registered).
- busy  output  1  1 while in RUN.
- tc  output  1  one-cycle terminal-count pulse.
- done  output  1  one-shot complete; level-sensitive, held until load or start.

Behaviour:
- Reset (reset_n=0, async, no clock needed):
  - count=0, reload_reg=0, prescaler=0, busy=0, tc=0, done=0, state=IDLE.
  - Held while low; the first active edge is the first rising clk with reset_n=1.
- States: IDLE, RUN, PAUSE, DONE. busy = (state==RUN). All outputs are registered.
- Priority per edge: load > stop > start.
- load (any state):
  - reload_reg<=load_val, count<=load_val, prescaler<=0, done<=0, tc<=0, state->IDLE.
  - start or stop in the same cycle is ignored.
- start:
  - IDLE: if count!=0 -> RUN, prescaler<=0. If count==0, ignored.
  - DONE: if reload_reg!=0 -> count<=reload_reg, done<=0, prescaler<=0, state->RUN. Otherwise ignored.
  - PAUSE: -> RUN. count and prescaler are retained (no restart).
  - RUN: ignored.
- stop:
  - RUN -> PAUSE; count and prescaler are frozen.
  - Ignored in all other states.
- Tick: in RUN, tick = (prescaler==PRESCALE-1). On a tick prescaler<=0; otherwise prescaler+1. The prescaler is frozen outside RUN.
- On a tick in RUN:
  - count>1: count<=count-1.
  - count==1: count<=0 and tc<=1 (tc is high in the same cycle count shows 0).
    - If auto_reload==0: state->DONE, done<=1, busy drops at the same edge.
    - If auto_reload==1: stay in RUN.
  - count==0 (auto-reload only): count<=reload_reg, no tc. Period = (reload_reg+1)*PRESCALE clk.
  - If auto_reload is cleared while count==0 in RUN: the next tick goes to DONE with done<=1 and no extra tc.
- tc deasserts on the next edge (single-cycle pulse).
- Latency:
  - start sampled at edge N: busy=1 after N; first decrement at edge N+PRESCALE.
  - load sampled at edge N: count shows load_val after N.
- Width: pure unsigned decrement. There is no underflow below 0; count never wraps to all-ones.
- DONE: count holds 0 and outputs are stable until load or start.
- Reset mid-operation: immediate clear regardless of state; any in-progress tc is cleared.

Test Plan:
- reset_n=0 for 15 ns, then release -> count=0, busy=0, tc=0, done=0; no change over 5 clks without load.
- WIDTH=4, PRESCALE=1: load 5, then start, auto_reload=0 -> count 5,4,3,2,1,0 on consecutive edges; tc=1 for exactly the one cycle count==0; done=1 and busy=0 from that edge; count holds 0; a later start restarts from 5.
- auto_reload=1, load 3, start -> 3,2,1,0,3,2,1,0,...; tc pulses every 4 clks; busy stays 1; done never asserts.
- Load 9, start; stop when count==6 -> count holds 6 in PAUSE for 4 clks, busy=0. Then start -> 5 on the next tick. stop and start together in RUN -> PAUSE.
- PRESCALE=3: load 2, start -> count decrements every 3 clks (2 at 3 clks, then 1, then 0); tc once.
- Edge cases:
  - load and start together -> IDLE with count=load_val, no run.
  - start with count 0 after reset -> ignored.
  - reset_n low between edges at count=7 -> count=0 immediately without a clk edge.

Source files
------------

// File: rtl/down_counter_timer.sv
// Programmable down-counting timer with a prescaler, one-shot/auto-reload modes and pause/resume.
// Terminal count raises a single-cycle tc pulse; a one-shot run finishing also latches done.
//
//   state | meaning
//   IDLE  | loaded or reset; waiting for start with a non-zero count
//   RUN   | counting down on prescaled ticks (busy=1)
//   PAUSE | stopped mid-run; count and prescaler frozen
//   DONE  | one-shot expired; count holds 0 and done=1
module down_counter_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             busy_q, busy_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         presc_q  <= '0;
         busy_q   <= 1'b0;
         tc_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         presc_q  <= presc_d;
         busy_q   <= busy_d;
         tc_q     <= tc_d;
         done_q   <= done_d;
      end
   end

   assign tick = (presc_q == PRESC_LAST);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      presc_d  = presc_q;
      tc_d     = 1'b0;
      done_d   = done_q;

      if (load) begin
         reload_d = load_val;
         count_d  = load_val;
         presc_d  = '0;
         done_d   = 1'b0;
         state_d  = IDLE;
      end else if (stop) begin
         // stop outranks start, so a simultaneous start never resumes
         if (state_q == RUN) begin
            state_d = PAUSE;
         end
      end else if (state_q == RUN) begin
         if (tick) begin
            presc_d = '0;
            if (count_q > WIDTH'(1)) begin
               count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
               count_d = '0;
               tc_d    = 1'b1;
               if (!auto_reload) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else if (auto_reload) begin
               count_d = reload_q;
            end else begin
               // auto_reload dropped while parked at 0: finish without a second tc
               state_d = DONE;
               done_d  = 1'b1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else if (start) begin
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
            DONE: begin
               if (reload_q != '0) begin
                  count_d = reload_q;
                  done_d  = 1'b0;
                  presc_d = '0;
                  state_d = RUN;
               end
            end
            PAUSE:   state_d = RUN;
            default: state_d = state_q;
         endcase
      end

      busy_d = (state_d == RUN);
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign tc    = tc_q;
   assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: one instance at PRESCALE=1, one at PRESCALE=3,
// sharing clock, reset and control inputs; expected values are hand-computed constants.
module tb_down_counter_timer;

   logic       clk;
   logic       reset_n;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       stop;
   logic       auto_reload;
   logic [3:0] count, count3;
   logic       busy, busy3;
   logic       tc, tc3;
   logic       done, done3;

   int n_cmp = 0;
   int n_err = 0;

   down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .auto_reload(auto_reload),
      .count(count), .busy(busy), .tc(tc), .done(done)
   );

   down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .auto_reload(auto_reload),
      .count(count3), .busy(busy3), .tc(tc3), .done(done3)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
      check({tag, ".count"}, int'(count), c);
      check({tag, ".busy"},  int'(busy),  b);
      check({tag, ".tc"},    int'(tc),    t);
      check({tag, ".done"},  int'(done),  d);
   endtask

   initial begin
      int ar_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
      int p3_seq [6] = '{2, 2, 1, 1, 1, 0};
      int tc_cnt;

      reset_n = 1'b0; load = 1'b0; load_val = '0;
      start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

      #2;
      chk_all("rst_held", 0, 0, 0, 0);
      #13;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_all("rst_idle", 0, 0, 0, 0);
      end

      // start with count 0 is ignored
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("start_zero", 0, 0, 0, 0);

      // one-shot from 5
      load_val = 4'd5; load = 1'b1; cyc(); load = 1'b0;
      chk_all("load5", 5, 0, 0, 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("os_start", 5, 1, 0, 0);
      for (int i = 4; i >= 1; i--) begin
         cyc();
         chk_all("os_dec", i, 1, 0, 0);
      end
      cyc();
      chk_all("os_tc", 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_all("os_hold", 0, 0, 0, 1);
      end
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("os_restart", 5, 1, 0, 0);
      cyc();
      chk_all("os_restart_dec", 4, 1, 0, 0);

      // auto-reload from 3
      auto_reload = 1'b1;
      load_val = 4'd3; load = 1'b1; cyc(); load = 1'b0;
      chk_all("ar_load", 3, 0, 0, 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("ar_start", 3, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk_all("ar_seq", ar_seq[i], 1, (ar_seq[i] == 0) ? 1 : 0, 0);
      end
      cyc(); chk_all("ar_tail", 2, 1, 0, 0);
      cyc(); chk_all("ar_tail", 1, 1, 0, 0);
      cyc(); chk_all("ar_tail", 0, 1, 1, 0);
      auto_reload = 1'b0;
      cyc();
      chk_all("ar_clear_done", 0, 0, 0, 1);

      // pause and resume
      load_val = 4'd9; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("pz_start", 9, 1, 0, 0);
      cyc(); cyc(); cyc();
      chk_all("pz_at6", 6, 1, 0, 0);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk_all("pz_stop", 6, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_all("pz_hold", 6, 0, 0, 0);
      end
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("pz_resume", 6, 1, 0, 0);
      cyc();
      chk_all("pz_dec", 5, 1, 0, 0);
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      chk_all("pz_stop_start", 5, 0, 0, 0);
      cyc();
      chk_all("pz_stop_start_hold", 5, 0, 0, 0);

      // PRESCALE=3 instance
      load_val = 4'd2; load = 1'b1; cyc(); load = 1'b0;
      check("p3_load.count", int'(count3), 2);
      start = 1'b1; cyc(); start = 1'b0;
      check("p3_start.busy", int'(busy3), 1);
      check("p3_start.count", int'(count3), 2);
      tc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         check("p3_seq.count", int'(count3), p3_seq[i]);
         tc_cnt += int'(tc3);
      end
      check("p3_done", int'(done3), 1);
      check("p3_busy", int'(busy3), 0);
      cyc();
      tc_cnt += int'(tc3);
      check("p3_tc_once", tc_cnt, 1);

      // load and start together: load wins, no run
      load_val = 4'd4; load = 1'b1; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
      chk_all("ld_st", 4, 0, 0, 0);
      cyc();
      chk_all("ld_st_hold", 4, 0, 0, 0);

      // async reset mid-run
      load_val = 4'd7; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk_all("ar7_run", 7, 1, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0);
      #3;
      reset_n = 1'b1;
      cyc();
      chk_all("post_rst", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
